clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Run/stop and ratio controller for a locally generated divided clock, so the divided clock no longer depends on free-running flops.
- Produces a registered divided clock clk_o and a one-cycle period-boundary strobe tick_o from clk_i.
- Accepts a new divide ratio through a valid/ready handshake and applies it only at a period boundary, so clk_o never shows a runt pulse.
- Sits between configuration logic and any logic clocked or enabled by the divided clock.

Parameters:
- DIV_W, 8, width of the divide-ratio field and of the period counter.
- DEFAULT_DIV, 4, ratio loaded at reset. Must be in the range 2..2^DIV_W-1.

Ports:
- clk_i  input  1  single clock. All logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  level. 1 = produce the divided clock, 0 = stop at the end of the current period.
- cfg_valid  input  1  a new ratio is offered on cfg_div.
- cfg_div  input  DIV_W  requested divide ratio N.
- cfg_ready  output  1  the controller can accept a ratio.
- clk_o  output  1  registered divided clock.
- tick_o  output  1  one-cycle pulse on the last clk_i cycle of each period.
- busy_o  output  1  1 while the state is not IDLE.
- div_o  output  DIV_W  ratio currently in effect.

Behaviour:
- Reset (rst=1 at an edge) has priority over everything and may be applied mid-period. It sets:
  - state=IDLE, cnt=0, div_cur=DEFAULT_DIV, pend_v=0;
  - clk_o=0, tick_o=0, busy_o=0, cfg_ready=1, div_o=DEFAULT_DIV.
  - Any pending ratio is discarded.
- All outputs are registered. Stated values are the values after the named edge.
- States:
  - IDLE: cnt held at 0, clk_o=0, tick_o=0.
  - RUN: counting.
  - STOP: finish the current period, then return to IDLE.
- IDLE -> RUN at an edge where run=1. After that edge:
  - cnt=0, clk_o=1.
  - If pend_v=1, the pending ratio is loaded into div_cur at this same edge and pend_v clears.
- In RUN or STOP, each edge does cnt = (cnt==div_cur-1) ? 0 : cnt+1.
- clk_o after an edge = (new cnt < div_cur/2), using integer division.
  - Odd N gives floor(N/2) cycles high and ceil(N/2) cycles low.
  - Every period starts high.
- tick_o after an edge = (new cnt == div_cur-1). It is high exactly one clk_i cycle per period.
- Boundary edge (wrap): an edge where the old cnt == div_cur-1.
  - If pend_v=1: div_cur takes pend_div, pend_v clears, and clk_o/tick_o for new cnt=0 are computed with the new ratio.
  - RUN -> STOP when run=0 at any edge.
  - STOP -> RUN if run returns to 1 before the boundary edge; counting continues without a break.
  - STOP -> IDLE at the boundary edge when run=0; clk_o=0 and cnt=0 after that edge.
  - A period is never truncated.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready. It loads pend_div = max(cfg_div, 2) and sets pend_v=1. Values 0 and 1 are clamped to 2.
  - cfg_ready = ~pend_v.
- Simultaneous events:
  - A transfer at an edge that is also a boundary or an IDLE->RUN edge is applied at the next boundary, not at this edge.
  - In IDLE with run=0, a pending ratio is applied at the next edge, which clears pend_v.
- div_o = div_cur. busy_o = (state != IDLE).

Test Plan:
- Reset with run=1 continuous and default N=4:
  - clk_o after successive edges is 1,1,0,0,1,1,0,0.
  - tick_o is high on every 4th cycle, coincident with the second 0.
  - busy_o=1 from the first edge.
- Odd ratio: cfg_div=5 in IDLE, then run=1.
  - div_o=5.
  - clk_o pattern is 1,1,0,0,0 repeating, with one tick per 5 cycles.
- Ratio change mid-period: N=4 running, transfer cfg_div=6 at cnt=1.
  - cfg_ready=0 until the boundary.
  - Current period completes with 4 cycles; the next period has 6 cycles (1,1,1,0,0,0).
  - div_o changes at the boundary edge, and cfg_ready returns to 1.
- Stop: run drops at cnt=1 with N=8.
  - clk_o completes the 8-cycle period.
  - State goes to IDLE at the wrap; clk_o=0 and busy_o=0 afterwards.
  - Re-asserting run at cnt=5 keeps the output continuous with no IDLE.
- Clamp and back-pressure: transfer cfg_div=0 -> div_o=2 after the boundary. A second cfg_valid while pend_v=1 is held off (cfg_ready=0) and accepted one cycle after the boundary.
- Reset mid-period at cnt=3 of N=8 with a pending ratio:
  - Next cycle: clk_o=0, tick_o=0, cfg_ready=1, div_o=DEFAULT_DIV.
  - The pending ratio is never applied.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Run/stop and ratio controller for a registered divided clock.
// A new ratio is staged and only applied at a period boundary, so clk_o never shows a runt pulse.
module clk_div_ctrl #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_o,
    output logic             tick_o,
    output logic             busy_o,
    output logic [DIV_W-1:0] div_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_cur;
    logic [DIV_W-1:0] pend_div;
    logic             pend_v;

    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] cfg_clamped;
    logic             wrap;
    logic             apply;
    logic             xfer;
    logic             pend_v_nxt;
    logic             clk_nxt;
    logic             tick_nxt;

    // Next-state datapath; a ratio staged this edge waits for the next boundary.
    always_comb begin
        wrap        = (state != IDLE) && (cnt == div_cur - DIV_W'(1));
        apply       = pend_v && ((state == IDLE) || wrap);
        div_nxt     = apply ? pend_div : div_cur;
        xfer        = cfg_valid && !pend_v;
        cfg_clamped = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
        pend_v_nxt  = xfer || (pend_v && !apply);

        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = RUN;
            RUN:     if (!run) state_nxt = STOP;
            STOP: begin
                if (run)       state_nxt = RUN;
                else if (wrap) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if ((state == IDLE) || (state_nxt == IDLE) || wrap)
            cnt_nxt = '0;
        else
            cnt_nxt = cnt + DIV_W'(1);

        clk_nxt  = (state_nxt != IDLE) && (cnt_nxt < (div_nxt >> 1));
        tick_nxt = (state_nxt != IDLE) && (cnt_nxt == div_nxt - DIV_W'(1));
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            div_cur   <= DIV_W'(DEFAULT_DIV);
            pend_div  <= DIV_W'(DEFAULT_DIV);
            pend_v    <= 1'b0;
            clk_o     <= 1'b0;
            tick_o    <= 1'b0;
            busy_o    <= 1'b0;
            cfg_ready <= 1'b1;
            div_o     <= DIV_W'(DEFAULT_DIV);
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            div_cur   <= div_nxt;
            pend_v    <= pend_v_nxt;
            if (xfer)
                pend_div <= cfg_clamped;
            clk_o     <= clk_nxt;
            tick_o    <= tick_nxt;
            busy_o    <= (state_nxt != IDLE);
            cfg_ready <= !pend_v_nxt;
            div_o     <= div_nxt;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: a period-level model checked every cycle,
// plus hand-computed waveform patterns for the key scenarios.
module tb_clk_div_ctrl;

    localparam int unsigned DIV_W       = 8;
    localparam int unsigned DEFAULT_DIV = 4;

    logic             clk_i = 1'b0;
    logic             rst = 1'b1;
    logic             run = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             cfg_ready;
    logic             clk_o;
    logic             tick_o;
    logic             busy_o;
    logic [DIV_W-1:0] div_o;

    clk_div_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .clk_i     (clk_i),
        .rst       (rst),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clk_o     (clk_o),
        .tick_o    (tick_o),
        .busy_o    (busy_o),
        .div_o     (div_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    // Model: is a period in progress, where are we in it, which ratio, what is queued.
    logic m_active = 1'b0;
    logic m_stop = 1'b0;
    int   m_pos = 0;
    int   m_ratio = DEFAULT_DIV;
    int   m_pend[$];

    logic [15:0] tr_clk, tr_tick, tr_busy, tr_rdy;

    task automatic model_edge();
        logic acc;
        if (rst) begin
            m_active = 1'b0;
            m_stop   = 1'b0;
            m_pos    = 0;
            m_ratio  = DEFAULT_DIV;
            m_pend.delete();
        end else begin
            acc = cfg_valid && (m_pend.size() == 0);
            if (!m_active) begin
                if (m_pend.size() != 0) m_ratio = m_pend.pop_front();
                m_pos    = 0;
                m_active = run;
                m_stop   = 1'b0;
            end else begin
                if (m_pos == m_ratio - 1) begin
                    if (m_pend.size() != 0) m_ratio = m_pend.pop_front();
                    m_pos = 0;
                    if (m_stop && !run) m_active = 1'b0;
                end else begin
                    m_pos = m_pos + 1;
                end
                m_stop = !run;
            end
            if (acc) m_pend.push_back((int'(cfg_div) < 2) ? 2 : int'(cfg_div));
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (chk_en) begin
            logic e_clk, e_tick;
            e_clk  = m_active && (m_pos < m_ratio / 2);
            e_tick = m_active && (m_pos == m_ratio - 1);
            checks = checks + 5;
            if (clk_o !== e_clk) begin
                failures++;
                $display("FAIL model_clk t=%0t got=%b exp=%b", $time, clk_o, e_clk);
            end
            if (tick_o !== e_tick) begin
                failures++;
                $display("FAIL model_tick t=%0t got=%b exp=%b", $time, tick_o, e_tick);
            end
            if (busy_o !== m_active) begin
                failures++;
                $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy_o, m_active);
            end
            if (cfg_ready !== (m_pend.size() == 0)) begin
                failures++;
                $display("FAIL model_ready t=%0t got=%b exp=%b", $time, cfg_ready, (m_pend.size() == 0));
            end
            if (div_o !== DIV_W'(m_ratio)) begin
                failures++;
                $display("FAIL model_div t=%0t got=%0d exp=%0d", $time, div_o, m_ratio);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic clr();
        tr_clk  = '0;
        tr_tick = '0;
        tr_busy = '0;
        tr_rdy  = '0;
    endtask

    // Drive one set of inputs for one clk_i edge; return just after the falling edge.
    task automatic step(input logic r, input logic rn, input logic v, input logic [DIV_W-1:0] d);
        rst       = r;
        run       = rn;
        cfg_valid = v;
        cfg_div   = d;
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        #1;
        tr_clk  = {tr_clk[14:0], clk_o};
        tr_tick = {tr_tick[14:0], tick_o};
        tr_busy = {tr_busy[14:0], busy_o};
        tr_rdy  = {tr_rdy[14:0], cfg_ready};
    endtask

    initial begin
        clr();
        @(negedge clk_i);
        #1;

        // Reset state, then continuous run at the default ratio of 4.
        step(1'b1, 1'b0, 1'b0, 8'd0);
        chk_en = 1'b1;
        chk("rst_clk", 16'(clk_o), 16'd0);
        chk("rst_tick", 16'(tick_o), 16'd0);
        chk("rst_busy", 16'(busy_o), 16'd0);
        chk("rst_ready", 16'(cfg_ready), 16'd1);
        chk("rst_div", 16'(div_o), 16'd4);
        clr();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'd0);
        chk("n4_clk", tr_clk[7:0], 16'b11001100);
        chk("n4_tick", tr_tick[7:0], 16'b00010001);
        chk("n4_busy", tr_busy[7:0], 16'hff);

        // Odd ratio staged in IDLE, applied while still idle.
        step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b1, 8'd5);
        chk("n5_stage_ready", 16'(cfg_ready), 16'd0);
        chk("n5_stage_div", 16'(div_o), 16'd4);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        chk("n5_idle_apply_div", 16'(div_o), 16'd5);
        clr();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'd0);
        chk("n5_clk", tr_clk[9:0], 16'b1100011000);
        chk("n5_tick", tr_tick[9:0], 16'b0000100001);

        // Ratio change 4 -> 6 offered at cnt=1.
        step(1'b1, 1'b0, 1'b0, 8'd0);
        clr();
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b1, 8'd6);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 8'd0);
        chk("n6_clk", tr_clk[9:0], 16'b1100111000);
        chk("n6_tick", tr_tick[9:0], 16'b0001000001);
        chk("n6_ready", tr_rdy[9:0], 16'b1100111111);
        chk("n6_div", 16'(div_o), 16'd6);

        // Stop at cnt=1 with N=8: full period, then idle.
        step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b1, 8'd8);
        clr();
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
        chk("stop_clk", tr_clk[8:0], 16'b111100000);
        chk("stop_busy", tr_busy[8:0], 16'b111111110);
        chk("stop_tick", tr_tick[8:0], 16'b000000010);
        // Drop run then re-assert before the boundary: no idle gap.
        clr();
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'd0);
        chk("resume_clk", tr_clk[8:0], 16'b111100001);
        chk("resume_busy", tr_busy[8:0], 16'b111111111);

        // Clamp of 0 to 2 and back-pressure on a second offer.
        step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b1, 8'd0);
        chk("clamp_ready_low", 16'(cfg_ready), 16'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'd3);
        chk("clamp_div", 16'(div_o), 16'd2);
        chk("clamp_ready_back", 16'(cfg_ready), 16'd1);
        step(1'b0, 1'b1, 1'b1, 8'd3);
        chk("bp_accept_ready", 16'(cfg_ready), 16'd0);
        chk("bp_accept_div", 16'(div_o), 16'd2);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        chk("bp_apply_div", 16'(div_o), 16'd3);

        // Reset at cnt=3 of N=8 with a ratio pending.
        step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b1, 8'd8);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b1, 8'd5);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        chk("mid_pending_ready", 16'(cfg_ready), 16'd0);
        step(1'b1, 1'b1, 1'b0, 8'd0);
        chk("mid_rst_clk", 16'(clk_o), 16'd0);
        chk("mid_rst_tick", 16'(tick_o), 16'd0);
        chk("mid_rst_ready", 16'(cfg_ready), 16'd1);
        chk("mid_rst_div", 16'(div_o), 16'd4);
        chk("mid_rst_busy", 16'(busy_o), 16'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        chk("mid_rst_no_apply", 16'(div_o), 16'd4);
        clr();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'd0);
        chk("mid_rst_clk_after", tr_clk[3:0], 16'b1100);
        chk("mid_rst_div_after", 16'(div_o), 16'd4);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
